// File: rtl/dcache_dm_wb_pkg.sv
// Shared types and address-slicing constants for the direct-mapped write-back data cache.
package dcache_dm_wb_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned OFS_W       = 2;
    localparam int unsigned WORD_ADDR_W = ADDR_W - OFS_W;
    localparam int unsigned DEF_INDEX_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_GAP  = 2'd2,
        S_FILL = 2'd3
    } state_t;

    // Tag width left over once the word offset and index are removed.
    function automatic int unsigned tag_w(input int unsigned index_w);
        return WORD_ADDR_W - index_w;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage: valid/dirty/tag/data arrays with combinational lookup and one write port.
module dcache_array
    import dcache_dm_wb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_W,
    parameter int unsigned TAG_WIDTH   = tag_w(INDEX_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    input  logic [TAG_WIDTH-1:0]   rd_tag,
    output logic                   hit_c,
    output logic                   line_valid_c,
    output logic                   line_dirty_c,
    output logic [TAG_WIDTH-1:0]   line_tag_c,
    output logic [DATA_W-1:0]      line_data_c,
    input  logic [INDEX_WIDTH-1:0] wr_idx,
    input  logic                   wr_valid_en,
    input  logic                   wr_valid,
    input  logic                   wr_dirty_en,
    input  logic                   wr_dirty,
    input  logic                   wr_tag_en,
    input  logic [TAG_WIDTH-1:0]   wr_tag,
    input  logic                   wr_data_en,
    input  logic [DATA_W-1:0]      wr_data
);

    localparam int unsigned LINES = 2 ** INDEX_WIDTH;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [DATA_W-1:0]    data_q [LINES];

    assign line_valid_c = valid_q[rd_idx];
    assign line_dirty_c = dirty_q[rd_idx];
    assign line_tag_c   = tag_q[rd_idx];
    assign line_data_c  = data_q[rd_idx];
    assign hit_c        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    // Only the state bits are cleared; tag/data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (wr_valid_en) valid_q[wr_idx] <= wr_valid;
            if (wr_dirty_en) dirty_q[wr_idx] <= wr_dirty;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en)  tag_q[wr_idx]  <= wr_tag;
        if (wr_data_en) data_q[wr_idx] <= wr_data;
    end

endmodule

// File: rtl/dcache_dm_wb.sv
// Direct-mapped write-back/write-allocate data cache, one word per line, between core and a
// multi-cycle cs/we/ack RAM. Hits complete with zero wait states.
module dcache_dm_wb
    import dcache_dm_wb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_W,
    parameter int unsigned TAG_WIDTH   = tag_w(INDEX_WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_stall,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ack,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
);

    localparam int unsigned TAG_LSB = OFS_W + INDEX_WIDTH;

    state_t                 state;
    logic [WORD_ADDR_W-1:0] miss_word;

    logic [INDEX_WIDTH-1:0] cpu_idx;
    logic [TAG_WIDTH-1:0]   cpu_tag;
    logic [INDEX_WIDTH-1:0] miss_idx;
    logic [TAG_WIDTH-1:0]   miss_tag;
    logic                   unused_addr_bits;

    logic                   hit_c;
    logic                   line_valid_c;
    logic                   line_dirty_c;
    logic [TAG_WIDTH-1:0]   line_tag_c;
    logic [DATA_W-1:0]      line_data_c;

    logic                   idle_c;
    logic                   store_hit_c;
    logic                   miss_c;

    logic [INDEX_WIDTH-1:0] wr_idx_c;
    logic                   wr_valid_en_c;
    logic                   wr_valid_c;
    logic                   wr_dirty_en_c;
    logic                   wr_dirty_c;
    logic                   wr_tag_en_c;
    logic [TAG_WIDTH-1:0]   wr_tag_c;
    logic                   wr_data_en_c;
    logic [DATA_W-1:0]      wr_data_c;

    assign cpu_idx          = cpu_addr[OFS_W +: INDEX_WIDTH];
    assign cpu_tag          = cpu_addr[TAG_LSB +: TAG_WIDTH];
    assign miss_idx         = miss_word[INDEX_WIDTH-1:0];
    assign miss_tag         = miss_word[INDEX_WIDTH +: TAG_WIDTH];
    assign unused_addr_bits = ^cpu_addr[OFS_W-1:0];

    dcache_array #(
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .rd_idx       (cpu_idx),
        .rd_tag       (cpu_tag),
        .hit_c        (hit_c),
        .line_valid_c (line_valid_c),
        .line_dirty_c (line_dirty_c),
        .line_tag_c   (line_tag_c),
        .line_data_c  (line_data_c),
        .wr_idx       (wr_idx_c),
        .wr_valid_en  (wr_valid_en_c),
        .wr_valid     (wr_valid_c),
        .wr_dirty_en  (wr_dirty_en_c),
        .wr_dirty     (wr_dirty_c),
        .wr_tag_en    (wr_tag_en_c),
        .wr_tag       (wr_tag_c),
        .wr_data_en   (wr_data_en_c),
        .wr_data      (wr_data_c)
    );

    // Core-side handshake is combinational so hits need no wait state.
    assign idle_c      = (state == S_IDLE);
    assign store_hit_c = cpu_req && cpu_we && idle_c && hit_c;
    assign miss_c      = cpu_req && idle_c && !hit_c;
    assign cpu_stall   = cpu_req && (!idle_c || !hit_c);
    assign cpu_dout    = (cpu_req && !cpu_we && idle_c && hit_c) ? line_data_c : '0;

    // Array write port: store hit in idle, dirty clear after write-back, line install after fill.
    always_comb begin
        wr_idx_c      = idle_c ? cpu_idx : miss_idx;
        wr_valid_en_c = 1'b0;
        wr_valid_c    = 1'b0;
        wr_dirty_en_c = 1'b0;
        wr_dirty_c    = 1'b0;
        wr_tag_en_c   = 1'b0;
        wr_tag_c      = miss_tag;
        wr_data_en_c  = 1'b0;
        wr_data_c     = cpu_din;
        case (state)
            S_IDLE: begin
                if (store_hit_c) begin
                    wr_data_en_c  = 1'b1;
                    wr_dirty_en_c = 1'b1;
                    wr_dirty_c    = 1'b1;
                end
            end
            S_WB: begin
                if (mem_ack) wr_dirty_en_c = 1'b1;
            end
            S_FILL: begin
                if (mem_ack) begin
                    wr_data_en_c  = 1'b1;
                    wr_data_c     = mem_dout;
                    wr_tag_en_c   = 1'b1;
                    wr_valid_en_c = 1'b1;
                    wr_valid_c    = 1'b1;
                    wr_dirty_en_c = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Miss FSM with registered RAM interface; mem_addr/mem_din double as the victim latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            miss_word <= '0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
        end else begin
            if (cpu_req && !cpu_stall) hit_cnt <= hit_cnt + 32'd1;
            case (state)
                S_IDLE: begin
                    if (miss_c) begin
                        miss_cnt  <= miss_cnt + 32'd1;
                        miss_word <= cpu_addr[ADDR_W-1:OFS_W];
                        mem_cs    <= 1'b1;
                        if (line_valid_c && line_dirty_c) begin
                            state    <= S_WB;
                            mem_we   <= 1'b1;
                            mem_addr <= {line_tag_c, cpu_idx, 2'b00};
                            mem_din  <= line_data_c;
                        end else begin
                            state    <= S_FILL;
                            mem_we   <= 1'b0;
                            mem_addr <= {cpu_addr[ADDR_W-1:OFS_W], 2'b00};
                        end
                    end
                end
                S_WB: begin
                    if (mem_ack) begin
                        state  <= S_GAP;
                        mem_cs <= 1'b0;
                        mem_we <= 1'b0;
                    end
                end
                S_GAP: begin
                    state    <= S_FILL;
                    mem_cs   <= 1'b1;
                    mem_addr <= {miss_word, 2'b00};
                end
                S_FILL: begin
                    if (mem_ack) begin
                        state  <= S_IDLE;
                        mem_cs <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_dm_wb.md
Name: dcache_dm_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache with one 32-bit word per line.
- Sits between the core's data-memory port and the multi-cycle data RAM.
- Serves hits with zero wait states.
- On a miss, writes back a dirty victim if needed, then fills the line from the RAM using its cs/we/ack handshake.

Parameters:
- INDEX_WIDTH, 4, line index bits; the cache holds 2^INDEX_WIDTH lines.
- TAG_WIDTH, 30-INDEX_WIDTH, tag bits taken from addr[31:INDEX_WIDTH+2].

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- cpu_req  in  1  core access request
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address; bits [1:0] are ignored (word access)
- cpu_din  in  32  store data
- cpu_dout  out  32  load data, valid when cpu_req=1 and cpu_stall=0
- cpu_stall  out  1  core must hold the request stable
- mem_cs  out  1  RAM chip select
- mem_we  out  1  RAM write enable
- mem_addr  out  32  RAM word address (byte form, [1:0]=0)
- mem_din  out  32  write-back data
- mem_dout  in  32  RAM read data, valid when mem_ack=1
- mem_ack  in  1  RAM completion strobe, single cycle
- hit_cnt  out  32  count of completed hit cycles
- miss_cnt  out  32  count of detected misses

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While rst_n=0:
  - all valid and dirty bits clear; state = S_IDLE.
  - mem_cs=0, mem_we=0, mem_addr=0, mem_din=0.
  - hit_cnt=0, miss_cnt=0; cpu_stall follows its equation (=0 when cpu_req=0).
- Storage: valid[], dirty[], tag[], data[] are register arrays. Lookup is combinational on cpu_addr.
- Hit condition: valid[idx] and tag[idx]==cpu_addr tag.
- Load hit: cpu_dout = data[idx] in the same cycle; no stall.
- Store hit: data[idx] <= cpu_din and dirty[idx] <= 1 at the clock edge; no stall.
- cpu_dout = 0 when there is no load hit.
- cpu_stall = cpu_req & (state != S_IDLE | ~hit).
- States:
  - S_IDLE, on cpu_req miss: latch the miss address and victim tag/data and increment miss_cnt. Go to S_WB if the victim is valid and dirty, else go to S_FILL.
  - S_WB: mem_cs=1, mem_we=1, mem_addr = {victim tag, idx, 2'b00}, mem_din = victim data. On mem_ack: clear dirty[idx] and go to S_GAP.
  - S_GAP: mem_cs=0 for exactly one cycle, then go to S_FILL. The RAM must return to idle before a read follows a write.
  - S_FILL: mem_cs=1, mem_we=0, mem_addr = latched miss address. On mem_ack: data[idx] <= mem_dout, tag[idx] <= miss tag, valid <= 1, dirty <= 0, then go to S_IDLE.
- Miss retry: after returning to S_IDLE the same request is re-looked-up and hits. A store miss completes as a store hit in that cycle.
- mem_cs is driven only from the state register (no combinational path from cpu_*). It falls in the cycle after ack.
- Latency:
  - Clean miss: 3 stall cycles, data returned in the 4th cycle.
  - Dirty miss: 6 stall cycles, data returned in the 7th cycle.
  - Both figures assume the RAM acks one cycle after cs rises.
- hit_cnt increments on every cycle with cpu_req=1 and cpu_stall=0. The counters wrap modulo 2^32.
- cpu_req dropped mid-miss: the FSM finishes the write-back and fill; cpu_stall=0 while cpu_req=0.
- A changed cpu_addr during a stall is a protocol violation. The fill still uses the latched address.
- mem_ack outside S_WB/S_FILL is ignored.
- rst_n asserted mid-miss: everything aborts immediately and mem_cs drops asynchronously. The partial transfer is lost; no line is marked valid.

Decomposition:
- Shared package holds:
  - the state encoding: S_IDLE=0, S_WB=1, S_GAP=2, S_FILL=3 (2-bit).
  - the tag/index slicing helper constants derived from INDEX_WIDTH.
- One natural sub-module, dcache_array: valid/dirty/tag/data storage.
  - combinational lookup with a hit output.
  - a single write port with separate valid/dirty/tag/data enables.
  - asynchronous clear of valid/dirty.
- The FSM, address latch and counters stay in the top module.

Test Plan:
- Reset, then load 0x100 with RAM word 0x40 = 0xDEADBEEF:
  - stall high for 3 cycles, cpu_dout=0xDEADBEEF in cycle 4.
  - miss_cnt=1, hit_cnt=1.
- Repeat the load 0x100 -> no stall, cpu_dout=0xDEADBEEF, no mem_cs activity, hit_cnt=2.
- Store 0x12345678 to 0x100 (hit), then load 0x140 (same index 0, different tag), with INDEX_WIDTH=4 -> sequence in order:
  - S_WB with mem_we=1, mem_addr=0x100, mem_din=0x12345678.
  - one cycle with mem_cs=0.
  - S_FILL with mem_addr=0x140.
  - stall lasts 6 cycles.
- Store miss to 0x200 with cpu_din=0xA5A5A5A5 -> fill, then the store completes. A later eviction of index 0 writes back 0xA5A5A5A5 to 0x200.
- Pull rst_n low while in S_FILL -> mem_cs=0 immediately. After release, a load to the same address misses again (valid cleared) and both counters read 0 before it.
- Drop cpu_req in the cycle after miss detection -> fill still completes (valid set). A later load to the same address hits with zero stall.
